i2c_arm_board_slave: RTL

- I2C responder on the arm-board side of the myo_control I2C link. The elbow/arm controller master writes command frames to it and polls it for status.
- Decodes 4-byte register writes (register byte + 24-bit payload) into an 88-bit command frame. Commits the frame atomically and returns a 32-bit status word on read.
- Sits between the board's I2C pins and the local motor-command logic. Runs at 50 MHz; SCL is up to 400 kHz.

---
 rtl/i2c_arm_board_slave.sv | 284 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_arm_board_slave.sv
// I2C responder for the arm-board end of the myo_control link: decodes 4-byte
// register writes into an 88-bit command frame and serves a 32-bit status word.
module i2c_arm_board_slave #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [6:0]  device_id,
  input  logic [31:0] status,
  output logic [87:0] command_frame,
  output logic        frame_valid,
  output logic        busy,
  output logic        protocol_error
);
  localparam int FW = $clog2(FILTER_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_WACK, S_WDATA, S_RDATA, S_WAIT_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic [FW-1:0]          r_scl_cnt, r_sda_cnt;
  logic                   r_scl_f, r_sda_f, r_scl_d, r_sda_d;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t      r_state, n_state;
  logic [3:0]  r_bit, n_bit;
  logic [7:0]  r_shift, n_shift;
  logic        r_rw, n_rw;
  logic [6:0]  r_dev_id, n_dev_id;
  logic [2:0]  r_ptr, n_ptr, r_bidx, n_bidx;
  logic [1:0]  r_dcnt, n_dcnt;
  logic [23:0] r_acc, n_acc;
  logic [87:0] r_shadow, n_shadow, r_frame;
  logic [31:0] r_snap, n_snap;
  logic        r_pend, n_pend, r_commit, n_commit, r_fv;
  logic        r_busy, n_busy, r_err, n_err, r_oe, n_oe, r_mack, n_mack;
  logic [7:0]  w_sh_next, w_rbyte, w_nbyte;
  logic [23:0] w_acc_next;
  logic [2:0]  w_bidx_inc;

  function automatic logic [7:0] rd_byte(input logic [2:0] idx, input logic [31:0] snap);
    case (idx)
      3'd0:    return snap[31:24];
      3'd1:    return snap[23:16];
      3'd2:    return snap[15:8];
      3'd3:    return snap[7:0];
      default: return 8'hFF;
    endcase
  endfunction

  // A filtered level only moves after FILTER_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_cnt  <= '0;
      r_sda_cnt  <= '0;
      r_scl_f    <= 1'b1;
      r_sda_f    <= 1'b1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      if (r_scl_sync[SYNC_STAGES-1] != r_scl_f) begin
        if (r_scl_cnt == FW'(FILTER_CYCLES - 1)) begin
          r_scl_f   <= r_scl_sync[SYNC_STAGES-1];
          r_scl_cnt <= '0;
        end else begin
          r_scl_cnt <= r_scl_cnt + 1'b1;
        end
      end else begin
        r_scl_cnt <= '0;
      end
      if (r_sda_sync[SYNC_STAGES-1] != r_sda_f) begin
        if (r_sda_cnt == FW'(FILTER_CYCLES - 1)) begin
          r_sda_f   <= r_sda_sync[SYNC_STAGES-1];
          r_sda_cnt <= '0;
        end else begin
          r_sda_cnt <= r_sda_cnt + 1'b1;
        end
      end else begin
        r_sda_cnt <= '0;
      end
      r_scl_d <= r_scl_f;
      r_sda_d <= r_sda_f;
    end
  end

  assign w_scl_rise = r_scl_f & ~r_scl_d;
  assign w_scl_fall = ~r_scl_f & r_scl_d;
  assign w_start    = r_scl_f & r_scl_d & r_sda_d & ~r_sda_f;
  assign w_stop     = r_scl_f & r_scl_d & ~r_sda_d & r_sda_f;
  assign w_sh_next  = {r_shift[6:0], r_sda_f};
  assign w_acc_next = {r_acc[15:0], w_sh_next};
  assign w_bidx_inc = (r_bidx == 3'd4) ? 3'd4 : r_bidx + 3'd1;
  assign w_rbyte    = rd_byte(r_bidx, r_snap);
  assign w_nbyte    = rd_byte(w_bidx_inc, r_snap);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_bit    <= '0;
      r_shift  <= '0;
      r_rw     <= 1'b0;
      r_dev_id <= '0;
      r_ptr    <= '0;
      r_bidx   <= '0;
      r_dcnt   <= '0;
      r_acc    <= '0;
      r_shadow <= '0;
      r_frame  <= '0;
      r_snap   <= '0;
      r_pend   <= 1'b0;
      r_commit <= 1'b0;
      r_fv     <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      r_oe     <= 1'b0;
      r_mack   <= 1'b0;
    end else begin
      r_state  <= n_state;
      r_bit    <= n_bit;
      r_shift  <= n_shift;
      r_rw     <= n_rw;
      r_dev_id <= n_dev_id;
      r_ptr    <= n_ptr;
      r_bidx   <= n_bidx;
      r_dcnt   <= n_dcnt;
      r_acc    <= n_acc;
      r_shadow <= n_shadow;
      r_snap   <= n_snap;
      r_pend   <= n_pend;
      r_commit <= n_commit;
      r_busy   <= n_busy;
      r_err    <= n_err;
      r_oe     <= n_oe;
      r_mack   <= n_mack;
      r_fv     <= r_commit;
      if (r_commit) r_frame <= r_shadow;
    end
  end

  always_comb begin
    n_state  = r_state;
    n_bit    = r_bit;
    n_shift  = r_shift;
    n_rw     = r_rw;
    n_dev_id = r_dev_id;
    n_ptr    = r_ptr;
    n_bidx   = r_bidx;
    n_dcnt   = r_dcnt;
    n_acc    = r_acc;
    n_shadow = r_shadow;
    n_snap   = r_snap;
    n_pend   = r_pend;
    n_commit = 1'b0;
    n_busy   = r_busy;
    n_err    = r_err;
    n_oe     = r_oe;
    n_mack   = r_mack;
    if (w_stop) begin
      n_state  = S_IDLE;
      n_oe     = 1'b0;
      n_busy   = 1'b0;
      n_bit    = '0;
      n_commit = r_pend;
      n_pend   = 1'b0;
    end else if (w_start) begin
      n_state  = S_ADDR;
      n_oe     = 1'b0;
      n_bit    = '0;
      n_dev_id = device_id;
    end else begin
      case (r_state)
        S_ADDR: if (w_scl_rise) begin
          n_shift = w_sh_next;
          n_bit   = r_bit + 4'd1;
          if (r_bit == 4'd7) begin
            if (w_sh_next[7:1] == r_dev_id) begin
              n_state = S_ADDR_ACK;
              n_busy  = 1'b1;
              n_rw    = w_sh_next[0];
              n_snap  = status;
              n_bidx  = '0;
            end else begin
              n_state = S_IDLE;
            end
          end
        end
        // bit count 8 = first falling edge (drive ACK), 9 = end of ACK slot
        S_ADDR_ACK, S_WACK: if (w_scl_fall) begin
          if (r_bit == 4'd8) begin
            n_oe  = 1'b1;
            n_bit = 4'd9;
          end else begin
            n_bit = '0;
            if (r_state == S_ADDR_ACK && r_rw) begin
              n_state = S_RDATA;
              n_oe    = ~r_snap[31];
            end else begin
              n_oe    = 1'b0;
              n_state = (r_state == S_ADDR_ACK) ? S_REG : S_WDATA;
            end
          end
        end
        S_REG: if (w_scl_rise) begin
          n_shift = w_sh_next;
          n_bit   = r_bit + 4'd1;
          if (r_bit == 4'd7) begin
            if (w_sh_next >= 8'd1 && w_sh_next <= 8'd4) begin
              n_ptr   = w_sh_next[2:0];
              n_dcnt  = '0;
              n_state = S_WACK;
            end else begin
              n_err   = 1'b1;
              n_state = S_WAIT_STOP;
            end
          end
        end
        S_WDATA: if (w_scl_rise) begin
          n_shift = w_sh_next;
          n_bit   = r_bit + 4'd1;
          if (r_bit == 4'd7) begin
            if (r_dcnt == 2'd3) begin
              n_err   = 1'b1;
              n_state = S_WAIT_STOP;
            end else begin
              n_acc   = w_acc_next;
              n_dcnt  = r_dcnt + 2'd1;
              n_state = S_WACK;
              if (r_dcnt == 2'd2) begin
                case (r_ptr)
                  3'd1:    n_shadow[23:0]  = w_acc_next;
                  3'd2:    n_shadow[47:24] = w_acc_next;
                  3'd3:    n_shadow[71:48] = w_acc_next;
                  default: begin
                    n_shadow[87:72] = w_acc_next[15:0];
                    n_pend          = 1'b1;
                  end
                endcase
              end
            end
          end
        end
        S_RDATA: begin
          if (w_scl_rise) begin
            if (r_bit == 4'd8) begin
              n_mack = ~r_sda_f;
              n_bit  = 4'd9;
            end else if (r_bit < 4'd8) begin
              n_bit = r_bit + 4'd1;
            end
          end else if (w_scl_fall) begin
            if (r_bit < 4'd8) begin
              n_oe = ~w_rbyte[3'd7 - r_bit[2:0]];
            end else if (r_bit == 4'd8) begin
              n_oe = 1'b0;
            end else if (r_mack) begin
              n_bidx = w_bidx_inc;
              n_bit  = '0;
              n_oe   = ~w_nbyte[7];
            end else begin
              n_oe    = 1'b0;
              n_state = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_oe         = r_oe;
  assign command_frame  = r_frame;
  assign frame_valid    = r_fv;
  assign busy           = r_busy;
  assign protocol_error = r_err;
endmodule
